// File: rtl/bram_arbiter_pkg.sv
// Shared defaults for the BRAM arbiter slice: requester count and RAM geometry.
package bram_arbiter_pkg;

  localparam int BDPU_NUM_REQ    = 4;
  localparam int BDPU_DATA_WIDTH = 32;
  localparam int BDPU_ADD_WIDTH  = 10;

  // Width of a requester index / round-robin pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_arbiter_rr_pick.sv
// Round-robin winner selection: first asserted request at or after rr_ptr,
// scanning upward and wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import bram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = BDPU_NUM_REQ,
  localparam int PW     = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  // Scan from the pointer; the first hit wins, so gnt is one-hot or zero.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one registered-read BRAM between NUM_REQ
// requesters. Grant is combinational; RAM controls are registered; read data
// returns as a one-cycle rvalid pulse two cycles after the transfer edge.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = BDPU_NUM_REQ,
  parameter int DATA_WIDTH = BDPU_DATA_WIDTH,
  parameter int ADD_WIDTH  = BDPU_ADD_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADD_WIDTH-1:0]    req_add,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            ram_cs,
  output logic                            ram_we,
  output logic                            ram_oe,
  output logic [ADD_WIDTH-1:0]            ram_add,
  output logic [DATA_WIDTH-1:0]           ram_data_in,
  input  logic [DATA_WIDTH-1:0]           ram_data_out
);

  localparam int PW = ptr_width(NUM_REQ);

  logic [PW-1:0]         r_rr_ptr;
  logic                  r_ram_cs;
  logic                  r_ram_we;
  logic                  r_ram_oe;
  logic [ADD_WIDTH-1:0]  r_ram_add;
  logic [DATA_WIDTH-1:0] r_ram_data_in;
  logic [NUM_REQ-1:0]    r_rd_pend;
  logic [NUM_REQ-1:0]    r_rvalid;

  logic [NUM_REQ-1:0]    w_pick;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_xfer;
  logic [PW-1:0]         w_sel_idx;
  logic [PW-1:0]         w_next_ptr;
  logic                  w_sel_we;
  logic [ADD_WIDTH-1:0]  w_add_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .gnt    (w_pick)
  );

  // Unflatten per-requester address and write data.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_add_arr[gi]   = req_add[gi*ADD_WIDTH +: ADD_WIDTH];
    assign w_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Grant is forced low while reset is asserted.
  assign w_gnt  = rst ? '0 : w_pick;
  assign gnt    = w_gnt;
  assign w_xfer = |w_gnt;

  // Encode the one-hot grant into the winner index and its next pointer.
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_sel_idx = PW'(i);
    end
    w_next_ptr = (w_sel_idx == PW'(NUM_REQ - 1)) ? '0 : w_sel_idx + PW'(1);
    w_sel_we   = req_we[w_sel_idx];
  end

  // Register the RAM command, advance the pointer and pipeline read returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr      <= '0;
      r_ram_cs      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_oe      <= 1'b0;
      r_ram_add     <= '0;
      r_ram_data_in <= '0;
      r_rd_pend     <= '0;
      r_rvalid      <= '0;
    end else begin
      r_ram_cs  <= w_xfer;
      r_ram_we  <= w_xfer & w_sel_we;
      r_ram_oe  <= w_xfer & ~w_sel_we;
      r_rd_pend <= (w_xfer && !w_sel_we) ? w_gnt : '0;
      r_rvalid  <= r_rd_pend;
      if (w_xfer) begin
        r_rr_ptr      <= w_next_ptr;
        r_ram_add     <= w_add_arr[w_sel_idx];
        r_ram_data_in <= w_wdata_arr[w_sel_idx];
      end
    end
  end

  assign ram_cs      = r_ram_cs;
  assign ram_we      = r_ram_we;
  assign ram_oe      = r_ram_oe;
  assign ram_add     = r_ram_add;
  assign ram_data_in = r_ram_data_in;
  assign rvalid      = r_rvalid;
  assign rdata       = ram_data_out;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: a behavioural RAM plus a reference
// model of grants, RAM commands and read returns.
module tb_bram_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_add;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            ram_cs, ram_we, ram_oe;
  logic [AW-1:0]   ram_add;
  logic [DW-1:0]   ram_data_in;
  logic [DW-1:0]   ram_data_out;

  bram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_we       (req_we),
    .req_add      (req_add),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .ram_cs       (ram_cs),
    .ram_we       (ram_we),
    .ram_oe       (ram_oe),
    .ram_add      (ram_add),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM with registered read.
  logic [DW-1:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_add] <= ram_data_in;
      if (ram_oe) ram_data_out <= ram_mem[ram_add];
    end
  end

  // Reference model state.
  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            cyc;
  } rd_t;

  rd_t           sb_q[$];
  rd_t           mon_e;
  logic [DW-1:0] ref_mem [1024];
  int            ref_ptr;
  int            waitx [N];
  logic          exp_cs, exp_we, exp_oe;
  logic [AW-1:0] exp_add;
  logic [DW-1:0] exp_din;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  int            win;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    ref_ptr = 0;
    exp_cs = 0; exp_we = 0; exp_oe = 0; exp_add = '0; exp_din = '0;
    for (int i = 0; i < N; i++) waitx[i] = 0;
  endtask

  // One clock: check registered RAM controls and grant at the negedge,
  // advance the model, then return 1 time unit after the next posedge.
  task automatic step(output int w);
    logic [N-1:0] eg;
    int a;
    @(negedge clk);
    chk("ram_cs", ram_cs, exp_cs);
    chk("ram_we", ram_we, exp_we);
    chk("ram_oe", ram_oe, exp_oe);
    chk("ram_add", ram_add, exp_add);
    chk("ram_data_in", ram_data_in, exp_din);
    eg = '0;
    w  = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        a = (ref_ptr + k) % N;
        if (w < 0 && req[a]) begin
          w     = a;
          eg[a] = 1'b1;
        end
      end
    end
    chk("gnt", gnt, eg);
    if (!rst) begin
      if (w >= 0) begin
        for (int i = 0; i < N; i++) if (req[i] && i != w) waitx[i]++;
        chk("starvation_wait_over_limit", waitx[w] > N - 1, 0);
        waitx[w] = 0;
        ref_ptr  = (w + 1) % N;
        exp_cs   = 1'b1;
        exp_we   = req_we[w];
        exp_oe   = ~req_we[w];
        exp_add  = req_add[w*AW +: AW];
        exp_din  = req_wdata[w*DW +: DW];
        if (req_we[w]) ref_mem[exp_add] = exp_din;
        else sb_q.push_back('{w, ref_mem[exp_add], cyc + 2});
      end else begin
        exp_cs = 1'b0; exp_we = 1'b0; exp_oe = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setr(input int i, input bit r, input bit we, input int add, input logic [DW-1:0] d);
    req[i]               = r;
    req_we[i]            = we;
    req_add[i*AW +: AW]  = AW'(add);
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic drain();
    int w;
    req = '0;
    repeat (4) step(w);
  endtask

  // Monitor: pop and compare whenever the DUT presents read data.
  always @(negedge clk) begin
    if (rvalid !== '0) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rvalid_unexpected: got 0x%0h, expected 0x0 (cycle %0d)", rvalid, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rvalid", rvalid, 4'b0001 << mon_e.idx);
        chk("rdata", rdata, mon_e.data);
        chk("rd_latency_cycle", cyc, mon_e.cyc);
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      n_vec++; n_err++;
      $display("FAIL rvalid_missing: got 0x0, expected 0x%0h (cycle %0d)", 4'b0001 << sb_q[0].idx, cyc);
      void'(sb_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    ram_data_out = '0;
    rst = 1'b1;
    req = '0; req_we = '0; req_add = '0; req_wdata = '0;
    model_reset();

    // Reset state, with all requests asserted: grant must stay low.
    @(posedge clk); #1;
    req = 4'b1111;
    step(win);
    chk("rvalid_reset", rvalid, 0);
    rst = 1'b0;
    req = '0;

    // Four writes then eight reads with all requesters held: 0,1,2,3 repeating.
    for (int i = 0; i < N; i++) setr(i, 1, 1, 8 + i, $urandom);
    for (int k = 0; k < 12; k++) begin
      step(win);
      chk("rr_seq_all_req", win, k % N);
      if (win >= 0) req_we[win] = 1'b0;
    end
    drain();

    // Write then read-after-write on the very next cycle.
    setr(0, 1, 1, 5, 32'hDEADBEEF);
    step(win);
    setr(0, 1, 0, 5, 0);
    step(win);
    chk("raw_gnt_req0", win, 0);
    drain();

    // Single requester at full throughput: four writes, four reads.
    for (int k = 0; k < 4; k++) begin
      setr(2, 1, 1, k, $urandom);
      step(win);
      chk("req2_wr_every_cycle", win, 2);
    end
    for (int k = 0; k < 4; k++) begin
      setr(2, 1, 0, k, 0);
      step(win);
      chk("req2_rd_every_cycle", win, 2);
    end
    drain();

    // Pointer now at 3: requests 0 and 3 -> 3 first, then 0.
    setr(0, 1, 0, 2, 0);
    setr(3, 1, 0, 3, 0);
    step(win);
    chk("ptr3_first", win, 3);
    req[3] = 1'b0;
    step(win);
    chk("ptr3_second", win, 0);
    drain();

    // Reset one cycle after a read transfer discards the read.
    setr(0, 1, 0, 5, 0);
    step(win);
    rst = 1'b1;
    #1;
    chk("ram_cs_async_rst", ram_cs, 0);
    chk("rvalid_async_rst", rvalid, 0);
    model_reset();
    step(win);
    step(win);
    rst = 1'b0;
    drain();

    // First arbitration after reset starts from pointer 0.
    setr(1, 1, 0, 7, 0);
    setr(3, 1, 0, 9, 0);
    step(win);
    chk("post_rst_first", win, 1);
    req[1] = 1'b0;
    step(win);
    chk("post_rst_second", win, 3);
    drain();

    // Random traffic: requests held until granted, then replaced or dropped.
    win = -1;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (i == win || !req[i]) begin
          if ($urandom_range(0, 3) != 0)
            setr(i, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
          else
            req[i] = 1'b0;
        end
      end
      step(win);
    end
    drain();
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
